// File: rtl/sdram_arb.sv
// Two-port SDRAM request arbiter with refresh scheduling and fixed-length command slots.
// Optional B-port starvation guard enabled by defining SDRAM_ARB_FAIR_EN.
module sdram_arb #(
  parameter int unsigned SLOT = 7
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ready,
  input  logic        rfshReq,
  input  logic        aRd,
  input  logic        aWr,
  input  logic [23:0] aA,
  input  logic [15:0] aD,
  output logic        aAck,
  output logic        aDone,
  output logic [15:0] aQ,
  input  logic        bRd,
  input  logic        bWr,
  input  logic [23:0] bA,
  input  logic [15:0] bD,
  output logic        bAck,
  output logic        bDone,
  output logic [15:0] bQ,
  output logic        sdrRd,
  output logic        sdrWr,
  output logic        sdrRf,
  output logic [23:0] sdrA,
  output logic [15:0] sdrD,
  input  logic [15:0] sdrQ,
  output logic        busy
);

  localparam int unsigned CW = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_BUSY  = 2'd2;

  logic [1:0]    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          rp, rp_n;
  logic          sel_b, sel_b_n;
  logic          is_wr, is_wr_n;
  logic          is_rf, is_rf_n;
  logic          sdrRd_n, sdrWr_n, sdrRf_n;
  logic          aAck_n, bAck_n, aDone_n, bDone_n, busy_n;
  logic [23:0]   sdrA_n;
  logic [15:0]   sdrD_n, aQ_n, bQ_n;

  logic a_req, b_req, b_first, go;
  logic pick_rf, pick_a, pick_b, pick_wr;

  assign a_req = aRd | aWr;
  assign b_req = bRd | bWr;

`ifdef SDRAM_ARB_FAIR_EN
  // Counts A grants won while B waited; at 3, B takes the next non-refresh slot.
  logic [1:0] fair_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      fair_cnt <= 2'd0;
    end else if (state == ST_IDLE) begin
      if (!b_req || (go && pick_b)) begin
        fair_cnt <= 2'd0;
      end else if (go && pick_a) begin
        fair_cnt <= fair_cnt + 2'd1;
      end
    end
  end

  assign b_first = b_req && (fair_cnt == 2'd3);
`else
  assign b_first = 1'b0;
`endif

  assign go      = ready && (rp || a_req || b_req);
  assign pick_rf = rp;
  assign pick_b  = !rp && b_req && (!a_req || b_first);
  assign pick_a  = !rp && a_req && !pick_b;
  assign pick_wr = pick_b ? bWr : aWr;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      rp    <= 1'b0;
      sel_b <= 1'b0;
      is_wr <= 1'b0;
      is_rf <= 1'b0;
      sdrRd <= 1'b0;
      sdrWr <= 1'b0;
      sdrRf <= 1'b0;
      aAck  <= 1'b0;
      bAck  <= 1'b0;
      aDone <= 1'b0;
      bDone <= 1'b0;
      busy  <= 1'b0;
      sdrA  <= '0;
      sdrD  <= '0;
      aQ    <= '0;
      bQ    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      rp    <= rp_n;
      sel_b <= sel_b_n;
      is_wr <= is_wr_n;
      is_rf <= is_rf_n;
      sdrRd <= sdrRd_n;
      sdrWr <= sdrWr_n;
      sdrRf <= sdrRf_n;
      aAck  <= aAck_n;
      bAck  <= bAck_n;
      aDone <= aDone_n;
      bDone <= bDone_n;
      busy  <= busy_n;
      sdrA  <= sdrA_n;
      sdrD  <= sdrD_n;
      aQ    <= aQ_n;
      bQ    <= bQ_n;
    end
  end

  // Outputs are precomputed one cycle ahead so strobes land in ISSUE and Done on the slot's last busy cycle.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rp_n    = rp | rfshReq;
    sel_b_n = sel_b;
    is_wr_n = is_wr;
    is_rf_n = is_rf;
    sdrRd_n = 1'b0;
    sdrWr_n = 1'b0;
    sdrRf_n = 1'b0;
    aAck_n  = 1'b0;
    bAck_n  = 1'b0;
    aDone_n = 1'b0;
    bDone_n = 1'b0;
    busy_n  = busy;
    sdrA_n  = sdrA;
    sdrD_n  = sdrD;
    aQ_n    = aQ;
    bQ_n    = bQ;
    case (state)
      ST_IDLE: begin
        if (go) begin
          state_n = ST_ISSUE;
          busy_n  = 1'b1;
          sel_b_n = pick_b;
          is_rf_n = pick_rf;
          is_wr_n = pick_wr;
          sdrRf_n = pick_rf;
          sdrWr_n = !pick_rf && pick_wr;
          sdrRd_n = !pick_rf && !pick_wr;
          aAck_n  = pick_a;
          bAck_n  = pick_b;
          if (!pick_rf) begin
            sdrA_n = pick_b ? bA : aA;
            sdrD_n = pick_b ? bD : aD;
          end
        end
      end
      ST_ISSUE: begin
        state_n = ST_BUSY;
        cnt_n   = CW'(SLOT - 1);
        if (is_rf) begin
          rp_n = rfshReq;
        end
      end
      ST_BUSY: begin
        cnt_n = cnt - CW'(1);
        if ((cnt == CW'(2)) && !is_rf) begin
          aDone_n = !sel_b;
          bDone_n = sel_b;
        end
        if (cnt == CW'(1)) begin
          busy_n = 1'b0;
          if (!is_rf && !is_wr) begin
            if (sel_b) begin
              bQ_n = sdrQ;
            end else begin
              aQ_n = sdrQ;
            end
          end
        end
        if (cnt == '0) begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sdram_arb.sv
// Bench for sdram_arb: vector table, hand-written corner sequences, and a random run against a slot-timing model.
module tb_sdram_arb;

  localparam int unsigned SLOT = 7;
`ifdef SDRAM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset, ready, rfshReq;
  logic        aRd, aWr, bRd, bWr;
  logic [23:0] aA, bA, sdrA;
  logic [15:0] aD, bD, aQ, bQ, sdrD, sdrQ;
  logic        aAck, aDone, bAck, bDone, sdrRd, sdrWr, sdrRf, busy;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  sdram_arb #(.SLOT(SLOT)) dut (
    .clock(clock), .reset(reset), .ready(ready), .rfshReq(rfshReq),
    .aRd(aRd), .aWr(aWr), .aA(aA), .aD(aD), .aAck(aAck), .aDone(aDone), .aQ(aQ),
    .bRd(bRd), .bWr(bWr), .bA(bA), .bD(bD), .bAck(bAck), .bDone(bDone), .bQ(bQ),
    .sdrRd(sdrRd), .sdrWr(sdrWr), .sdrRf(sdrRf), .sdrA(sdrA), .sdrD(sdrD),
    .sdrQ(sdrQ), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        ard, awr, brd, bwr, rf;
    logic [23:0] a_addr, b_addr;
    logic [15:0] a_dat, b_dat, q;
    logic [2:0]  e_cmd;   // {sdrRd, sdrWr, sdrRf}
    logic [1:0]  e_ack;   // {aAck, bAck}
    logic [23:0] e_addr;
    logic [15:0] e_dat;
    logic [1:0]  e_done;  // {aDone, bDone}
    logic [15:0] e_aq, e_bq;
  } vec_t;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic clr();
    aRd = 0; aWr = 0; bRd = 0; bWr = 0; rfshReq = 0;
  endtask

  task automatic wait_idle();
    repeat (SLOT + 2) tick();
  endtask

  // One transaction from an idle arbiter with cycle-exact checks of strobe, Done, busy and Q.
  task automatic do_txn(input vec_t v, input int idx);
    string nm;
    nm = $sformatf("vec%0d", idx);
    if (v.rf) begin
      rfshReq = 1; tick(); rfshReq = 0;
    end
    aRd = v.ard; aWr = v.awr; aA = v.a_addr; aD = v.a_dat;
    bRd = v.brd; bWr = v.bwr; bA = v.b_addr; bD = v.b_dat;
    sdrQ = ~v.q;
    tick();
    chk({nm, "_issue"}, 96'({sdrRd, sdrWr, sdrRf, aAck, bAck, busy, sdrA, sdrD}),
        96'({v.e_cmd, v.e_ack, 1'b1, v.e_addr, v.e_dat}));
    clr();
    for (int k = 1; k <= int'(SLOT) - 1; k++) begin
      tick();
      chk({nm, "_slot"}, 96'({sdrRd | sdrWr | sdrRf, aAck | bAck, aDone, bDone, busy}),
          96'({2'b00, (k == int'(SLOT) - 1) ? v.e_done : 2'b00, 1'b1}));
      if (k == int'(SLOT) - 1) sdrQ = v.q;
    end
    tick();
    chk({nm, "_end"}, 96'({aDone, bDone, busy, aQ, bQ}), 96'({3'b000, v.e_aq, v.e_bq}));
    sdrQ = v.q ^ 16'h5555;
    tick();
  endtask

  initial begin
    vec_t tv[10];
    logic [7:0] exp_g;
    int sc[$];
    int kd[$];
    int g[$];
    int ns, dones, bad;
    logic [15:0] dw;

    tv[0] = '{1,0,0,0,0, 24'h000123, 24'h0, 16'h0, 16'h0, 16'hBEEF,
              3'b100, 2'b10, 24'h000123, 16'h0000, 2'b10, 16'hBEEF, 16'h0000};
    tv[1] = '{0,1,0,0,0, 24'h0000AA, 24'h0, 16'h1234, 16'h0, 16'hFFFF,
              3'b010, 2'b10, 24'h0000AA, 16'h1234, 2'b10, 16'hBEEF, 16'h0000};
    tv[2] = '{1,1,0,0,0, 24'h0000BB, 24'h0, 16'h5A5A, 16'h0, 16'h0F0F,
              3'b010, 2'b10, 24'h0000BB, 16'h5A5A, 2'b10, 16'hBEEF, 16'h0000};
    tv[3] = '{0,0,1,0,0, 24'h0, 24'hABCDEF, 16'h0, 16'h3333, 16'hC0DE,
              3'b100, 2'b01, 24'hABCDEF, 16'h3333, 2'b01, 16'hBEEF, 16'hC0DE};
    tv[4] = '{1,0,0,1,0, 24'h000777, 24'h000888, 16'h4444, 16'h8888, 16'h1111,
              3'b100, 2'b10, 24'h000777, 16'h4444, 2'b10, 16'h1111, 16'hC0DE};
    tv[5] = '{0,0,0,0,1, 24'h0, 24'h0, 16'h0, 16'h0, 16'h2222,
              3'b001, 2'b00, 24'h000777, 16'h4444, 2'b00, 16'h1111, 16'hC0DE};
    tv[6] = '{0,1,0,0,1, 24'h000999, 24'h0, 16'h9999, 16'h0, 16'h2222,
              3'b001, 2'b00, 24'h000777, 16'h4444, 2'b00, 16'h1111, 16'hC0DE};
    tv[7] = '{0,0,0,1,0, 24'h0, 24'h000001, 16'h0, 16'hFFFF, 16'h2222,
              3'b010, 2'b01, 24'h000001, 16'hFFFF, 2'b01, 16'h1111, 16'hC0DE};
    tv[8] = '{1,0,0,0,0, 24'hFFFFFF, 24'h0, 16'h0, 16'h0, 16'h0000,
              3'b100, 2'b10, 24'hFFFFFF, 16'h0000, 2'b10, 16'h0000, 16'hC0DE};
    tv[9] = '{0,0,1,0,0, 24'h0, 24'h000002, 16'h0, 16'h0, 16'hFFFF,
              3'b100, 2'b01, 24'h000002, 16'h0000, 2'b01, 16'h0000, 16'hFFFF};

    reset = 1; ready = 1; clr(); aA = 0; aD = 0; bA = 0; bD = 0; sdrQ = 16'h1357;
    repeat (3) tick();
    reset = 0;
    chk("reset_vals", 96'({sdrRd, sdrWr, sdrRf, aAck, bAck, aDone, bDone, busy, sdrA, sdrD, aQ, bQ}), 96'(0));

    for (int i = 0; i < 10; i++) do_txn(tv[i], i);

    // Refresh, A write and B read all arrive while ready is low.
    ready = 0; rfshReq = 1; aWr = 1; aA = 24'h000010; aD = 16'h5A5A; bRd = 1; bA = 24'h000020;
    tick();
    rfshReq = 0; ready = 1; dones = 0; dw = '0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (sdrRf | sdrWr | sdrRd) begin
        sc.push_back(cyc);
        kd.push_back(int'({sdrRd, sdrWr, sdrRf}));
        if (sdrWr) dw = sdrD;
      end
      if (aAck) aWr = 0;
      if (bAck) bRd = 0;
      if (aDone | bDone) dones++;
    end
    chk("order_count", 96'(sc.size()), 96'(3));
    while (sc.size() < 3) begin sc.push_back(0); kd.push_back(0); end
    chk("order_first_rf", 96'(kd[0]), 96'(3'b001));
    chk("order_second_wr", 96'(kd[1]), 96'(3'b010));
    chk("order_third_rd", 96'(kd[2]), 96'(3'b100));
    chk("spacing_1", 96'(sc[1] - sc[0]), 96'(SLOT + 2));
    chk("spacing_2", 96'(sc[2] - sc[1]), 96'(SLOT + 2));
    chk("order_wr_data", 96'(dw), 96'(16'h5A5A));
    chk("order_done_count", 96'(dones), 96'(2));
    clr(); wait_idle();

    // ready low holds off a pending request.
    ready = 0; aRd = 1; aA = 24'h000321; ns = 0;
    repeat (20) begin
      tick();
      if (sdrRd | sdrWr | sdrRf | aAck | busy) ns++;
    end
    chk("not_ready_quiet", 96'(ns), 96'(0));
    ready = 1;
    tick();
    chk("ready_rise_issue", 96'({sdrRd, aAck, sdrA}), 96'({2'b11, 24'h000321}));
    clr(); wait_idle();

    // Reset three cycles into a read slot.
    aRd = 1; aA = 24'h000456; sdrQ = 16'h7777;
    tick();
    chk("rst_slot_start", 96'({sdrRd, aAck}), 96'(2'b11));
    repeat (3) tick();
    reset = 1; bad = 0;
    repeat (3) begin
      tick();
      if (busy | aDone | sdrRd | aAck | (aQ != 16'h0) | (sdrA != 24'h0)) bad++;
    end
    chk("rst_mid_slot", 96'(bad), 96'(0));
    reset = 0;
    tick();
    chk("rst_reissue", 96'({sdrRd, aAck, busy, sdrA}), 96'({3'b111, 24'h000456}));
    clr(); wait_idle();

    // Both ports requesting continuously.
    aRd = 1; bRd = 1; aA = 24'h0000A0; bA = 24'h0000B0;
    for (int i = 0; i < 100 && g.size() < 8; i++) begin
      tick();
      if (aAck) g.push_back(0);
      if (bAck) g.push_back(1);
    end
    chk("grant_count", 96'(g.size()), 96'(8));
    while (g.size() < 8) g.push_back(2);
    exp_g = FAIR ? 8'b1000_1000 : 8'b0000_0000;
    for (int i = 0; i < 8; i++) chk($sformatf("grant_%0d", i), 96'(g[i]), 96'(exp_g[i]));
    clr(); wait_idle();

    // Random traffic against a slot-timing reference model.
    reset = 1; clr(); tick(); tick(); reset = 0;
    begin : rnd
      int m_s, m_free, m_k, m_fair;
      bit m_rp, m_b, rp_next, idle, ar, br, pb, pa_wr, pb_wr;
      logic [23:0] m_sa;
      logic [15:0] m_sd, m_aq, m_bq, m_cap;
      logic [7:0] flags;
      int r;
      m_s = -100; m_free = 0; m_k = 0; m_fair = 0; m_rp = 0; m_b = 0;
      m_sa = '0; m_sd = '0; m_aq = '0; m_bq = '0; m_cap = '0;
      for (int c = 0; c < 1500; c++) begin
        if (c == m_s + int'(SLOT) && m_k == 0) begin
          if (m_b) m_bq = m_cap; else m_aq = m_cap;
        end
        flags = {c == m_s && m_k == 0, c == m_s && m_k == 1, c == m_s && m_k == 2,
                 c == m_s && m_k != 2 && !m_b, c == m_s && m_k != 2 && m_b,
                 c == m_s + int'(SLOT) - 1 && m_k != 2 && !m_b,
                 c == m_s + int'(SLOT) - 1 && m_k != 2 && m_b,
                 c >= m_s && c <= m_s + int'(SLOT) - 1};
        chk("rand_cycle", 96'({sdrRd, sdrWr, sdrRf, aAck, bAck, aDone, bDone, busy, sdrA, sdrD, aQ, bQ}),
            96'({flags, m_sa, m_sd, m_aq, m_bq}));
        if (c == m_s && m_k != 2 && !m_b) begin aRd = 0; aWr = 0; end
        if (c == m_s && m_k != 2 && m_b) begin bRd = 0; bWr = 0; end
        if (!aRd && !aWr && $urandom_range(0, 3) == 0) begin
          r = $urandom_range(1, 3); aRd = r[0]; aWr = r[1]; aA = 24'($urandom); aD = 16'($urandom);
        end
        if (!bRd && !bWr && $urandom_range(0, 3) == 0) begin
          r = $urandom_range(1, 3); bRd = r[0]; bWr = r[1]; bA = 24'($urandom); bD = 16'($urandom);
        end
        rfshReq = ($urandom_range(0, 19) == 0);
        ready = ($urandom_range(0, 15) != 0);
        sdrQ = 16'($urandom);
        if (c == m_s + int'(SLOT) - 1) m_cap = sdrQ;
        // Arbitration decision for this cycle using the requests as the arbiter sees them.
        ar = aRd | aWr; br = bRd | bWr; pa_wr = aWr; pb_wr = bWr;
        rp_next = (c == m_s && m_k == 2) ? rfshReq : (m_rp | rfshReq);
        idle = (c >= m_free);
        if (idle && !br) m_fair = 0;
        if (idle && ready && (m_rp || ar || br)) begin
          m_s = c + 1;
          m_free = c + int'(SLOT) + 2;
          if (m_rp) begin
            m_k = 2;
          end else begin
            pb = br && (!ar || (FAIR && m_fair == 3));
            m_b = pb;
            m_k = (pb ? pb_wr : pa_wr) ? 1 : 0;
            m_sa = pb ? bA : aA;
            m_sd = pb ? bD : aD;
            if (pb) m_fair = 0;
            else if (br) m_fair = m_fair + 1;
          end
        end
        m_rp = rp_next;
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
